// File: rtl/acc_dispatch_pkg.sv
// Shared types and constants for the accelerator dispatch controller.
package acc_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OPC_NOP = 0;
  localparam int OPC_FFT = 1;
  localparam int OPC_FIR = 2;
  localparam int OPC_IIR = 3;

  localparam int DEFAULT_NUM_ACC = 3;

endpackage

// File: rtl/acc_watchdog.sv
// Loadable down-counter that flags expiry on the last permitted RUN cycle.
// With TIMEOUT_CYCLES=0 the watchdog is disabled and never expires.
module acc_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, i_clk, i_rst_n, i_load, i_run};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      // Loading T-1 makes expiry fall on the T-th RUN cycle, so the enable
      // stays high for exactly T cycles.
      localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] r_count;

      // Count down once per RUN cycle, saturating at zero.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_count <= '0;
        end else if (i_load) begin
          r_count <= LOAD_VAL;
        end else if (i_run && (r_count != '0)) begin
          r_count <= r_count - CNT_W'(1);
        end
      end

      assign o_expired = i_run && (r_count == '0);
    end
  endgenerate

endmodule

// File: rtl/acc_dispatch_ctrl.sv
// Dispatch controller: accepts one opcode, enables one accelerator, waits
// for its read and write completion (any order), then pulses completion.
// All outputs are registered.
module acc_dispatch_ctrl
  import acc_dispatch_pkg::*;
#(
  parameter int NUM_ACC        = DEFAULT_NUM_ACC,
  parameter int OPCODE_W       = 2,
  parameter int INSTR_W        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [NUM_ACC-1:0] read_done,
  input  logic [NUM_ACC-1:0] write_done,
  output logic [NUM_ACC-1:0] acc_enable,
  output logic               acc_done,
  output logic               acc_error,
  output logic               busy
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_ACC-1:0]   r_sel;
  logic [NUM_ACC-1:0]   w_sel_nxt;
  logic [NUM_ACC-1:0]   w_opc_onehot;
  logic [NUM_ACC-1:0]   w_en_nxt;
  logic                 r_rd_seen;
  logic                 r_wr_seen;
  logic                 w_rd_nxt;
  logic                 w_wr_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic                 w_wd_load;
  logic                 w_wd_expired;
  logic                 w_run;
  logic                 w_rd_sel;
  logic                 w_wr_sel;
  logic [OPCODE_W-1:0]  w_opcode;
  logic                 w_opc_nop;
  logic                 w_opc_legal;
  logic                 w_unused_instr;

  // Only the opcode field is decoded; the rest of the word is don't-care.
  assign w_opcode       = instruction[OPCODE_W-1:0];
  assign w_unused_instr = |instruction;

  // Opcode k (1..NUM_ACC) selects accelerator k-1; anything else is NOP or illegal.
  always_comb begin
    w_opc_onehot = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      w_opc_onehot[i] = (w_opcode == OPCODE_W'(i + 1));
    end
  end

  assign w_opc_nop   = (w_opcode == OPCODE_W'(OPC_NOP));
  assign w_opc_legal = |w_opc_onehot;

  // Done inputs of non-selected accelerators are masked off here.
  assign w_rd_sel = |(read_done & r_sel);
  assign w_wr_sel = |(write_done & r_sel);
  assign w_run    = (r_state == RUN);

  acc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_load    (w_wd_load),
    .i_run     (w_run),
    .o_expired (w_wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, capture flags and next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rd_nxt    = r_rd_seen;
    w_wr_nxt    = r_wr_seen;
    w_en_nxt    = '0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_wd_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          if (w_opc_legal) begin
            w_sel_nxt   = w_opc_onehot;
            w_rd_nxt    = 1'b0;
            w_wr_nxt    = 1'b0;
            w_wd_load   = 1'b1;
            w_en_nxt    = w_opc_onehot;
            w_state_nxt = RUN;
          end else if (!w_opc_nop) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        w_rd_nxt = r_rd_seen | w_rd_sel;
        w_wr_nxt = r_wr_seen | w_wr_sel;
        // Completion wins over a watchdog expiring in the same cycle.
        if (w_rd_nxt && w_wr_nxt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (w_wd_expired) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_en_nxt = r_sel;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs and run context.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel       <= '0;
      r_rd_seen   <= 1'b0;
      r_wr_seen   <= 1'b0;
      acc_enable  <= '0;
      acc_done    <= 1'b0;
      acc_error   <= 1'b0;
      busy        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      r_sel       <= w_sel_nxt;
      r_rd_seen   <= w_rd_nxt;
      r_wr_seen   <= w_wr_nxt;
      acc_enable  <= w_en_nxt;
      acc_done    <= w_done_nxt;
      acc_error   <= w_err_nxt;
      busy        <= (w_state_nxt != IDLE);
      instr_ready <= (w_state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_acc_dispatch_ctrl.sv
// Bench for acc_dispatch_ctrl: randomized runs scored against a queue of
// expected completions, plus a second instance (2 accelerators, watchdog off).
module tb_acc_dispatch_ctrl;

  localparam int NACC = 3;
  localparam int TMO  = 16;
  localparam int NEVER = 999;

  typedef struct {
    logic       done;
    logic       err;
    logic [2:0] en;
    int         len;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  read_done;
  logic [2:0]  write_done;
  logic [2:0]  acc_enable;
  logic        acc_done;
  logic        acc_error;
  logic        busy;

  logic [31:0] instr2;
  logic        valid2;
  logic        ready2;
  logic [1:0]  rd2;
  logic [1:0]  wr2;
  logic [1:0]  en2;
  logic        done2;
  logic        err2;
  logic        busy2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  acc_dispatch_ctrl #(
    .NUM_ACC(NACC), .OPCODE_W(2), .INSTR_W(32), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .read_done(read_done), .write_done(write_done),
    .acc_enable(acc_enable), .acc_done(acc_done), .acc_error(acc_error), .busy(busy)
  );

  acc_dispatch_ctrl #(
    .NUM_ACC(2), .OPCODE_W(2), .INSTR_W(32), .TIMEOUT_CYCLES(0)
  ) u_dut2 (
    .clk(clk), .reset(reset), .instruction(instr2), .instr_valid(valid2),
    .instr_ready(ready2), .read_done(rd2), .write_done(wr2),
    .acc_enable(en2), .acc_done(done2), .acc_error(err2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: completion happens in the RUN cycle where the later of the
  // two done inputs first appears, unless the T-cycle budget runs out first.
  function automatic exp_t model(input int opc, input int rd_dly, input int wr_dly);
    exp_t e;
    int   c;
    e.done = 1'b0;
    e.err  = 1'b0;
    e.en   = '0;
    e.len  = 0;
    if (opc > NACC) begin
      e.err = 1'b1;
      return e;
    end
    c      = (rd_dly > wr_dly) ? rd_dly : wr_dly;
    e.done = 1'b1;
    e.en   = 3'(1 << (opc - 1));
    if (c < TMO) begin
      e.len = c + 1;
    end else begin
      e.len = TMO;
      e.err = 1'b1;
    end
    return e;
  endfunction

  // Issue one instruction and drive the selected done inputs on schedule.
  task automatic run_txn(input int opc, input int rd_dly, input int wr_dly, input bit noise);
    logic [1:0] sel;
    bit         fin;
    instruction = ($urandom() & ~32'h3) | 32'(opc);
    instr_valid = 1'b1;
    read_done   = 3'($urandom());
    write_done  = 3'($urandom());
    if (opc != 0) exp_q.push_back(model(opc, rd_dly, wr_dly));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instruction = $urandom();
    read_done   = '0;
    write_done  = '0;
    if (opc == 0) begin
      chk("nop_ready", 32'(instr_ready), 32'd1);
      chk("nop_busy", 32'(busy), 32'd0);
      return;
    end
    sel = 2'(opc - 1);
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      read_done       = noise ? 3'($urandom()) : 3'd0;
      write_done      = noise ? 3'($urandom()) : 3'd0;
      read_done[sel]  = (k >= rd_dly);
      write_done[sel] = (k >= wr_dly);
      @(posedge clk); #1;
      if (instr_ready) fin = 1'b1;
    end
    read_done  = '0;
    write_done = '0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL txn_bound: opcode %0d never returned to ready, expected within 200 cycles", opc);
    end
  endtask

  // Monitor: measure each enable run and score every done/error pulse.
  initial begin : monitor
    exp_t       e;
    int         run_len;
    logic [2:0] last_en;
    bit         ready_next;
    run_len    = 0;
    last_en    = '0;
    ready_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_len    = 0;
        last_en    = '0;
        ready_next = 1'b0;
      end else begin
        if (ready_next) begin
          chk("ready_after_done", 32'(instr_ready), 32'd1);
          ready_next = 1'b0;
        end
        if (acc_done || acc_error) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: done=%0b error=%0b, expected no pulse", acc_done, acc_error);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_done", 32'(acc_done), 32'(e.done));
            chk("pulse_error", 32'(acc_error), 32'(e.err));
            chk("run_enable", 32'(last_en), 32'(e.en));
            chk("run_length", 32'(run_len), 32'(e.len));
            chk("enable_off_at_pulse", 32'(acc_enable), 32'd0);
            if (e.done) begin
              chk("ready_low_at_done", 32'(instr_ready), 32'd0);
              chk("busy_at_done", 32'(busy), 32'd1);
              ready_next = 1'b1;
            end
          end
          run_len = 0;
          last_en = '0;
        end else if (acc_enable != '0) begin
          if (acc_enable == last_en) begin
            run_len++;
          end else begin
            run_len = 1;
            last_en = acc_enable;
          end
        end
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int opc;
    int rd;
    int wr;
    int mode;
    int acc_cyc[4];
    bit got;

    reset       = 1'b0;
    instruction = '0;
    instr_valid = 1'b0;
    read_done   = '0;
    write_done  = '0;
    instr2      = '0;
    valid2      = 1'b0;
    rd2         = '0;
    wr2         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", 32'(acc_enable), 32'd0);
    chk("rst_done", 32'(acc_done), 32'd0);
    chk("rst_error", 32'(acc_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed runs: ordered completion, reversed with noise, timeout and its boundary.
    run_txn(1, 4, 7, 1'b0);
    run_txn(3, 5, 2, 1'b1);
    run_txn(2, NEVER, NEVER, 1'b0);
    run_txn(1, TMO - 1, 3, 1'b1);
    run_txn(2, TMO, TMO, 1'b0);
    run_txn(0, 0, 0, 1'b1);

    // Reset in the middle of a run drops it silently.
    instruction = 32'd1;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_enable", 32'(acc_enable), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_enable", 32'(acc_enable), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_ready", 32'(instr_ready), 32'd1);
    chk("mid_reset_done", 32'(acc_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_txn(1, 2, 5, 1'b1);

    // Back-to-back with valid held and all done inputs tied high.
    instr_valid = 1'b1;
    read_done   = '1;
    write_done  = '1;
    for (int i = 1; i <= 3; i++) begin
      instruction = 32'(i);
      exp_q.push_back(model(i, 0, 0));
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        if (instr_ready) got = 1'b1;
      end
      @(posedge clk); #1;
      acc_cyc[i] = cyc;
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL b2b_accept: instruction %0d not accepted within 20 cycles", i);
      end
    end
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_done  = '0;
    write_done = '0;
    chk("b2b_period_1_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    chk("b2b_period_2_3", 32'(acc_cyc[3] - acc_cyc[2]), 32'd3);

    // Randomized runs, including timeouts and expiry-cycle completions.
    repeat (40) begin
      opc  = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 9));
      case (mode)
        0: begin rd = NEVER; wr = int'($urandom_range(0, 20)); end
        1: begin rd = TMO - 1; wr = int'($urandom_range(0, TMO - 1)); end
        2: begin rd = int'($urandom_range(0, 20)); wr = TMO; end
        default: begin rd = int'($urandom_range(0, 8)); wr = int'($urandom_range(0, 8)); end
      endcase
      run_txn(opc, rd, wr, 1'($urandom_range(0, 1)));
    end

    // Two-accelerator instance: illegal opcode, NOP, and a disabled watchdog.
    instr2 = 32'h0000_0103;
    valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    chk("ill_error", 32'(err2), 32'd1);
    chk("ill_done", 32'(done2), 32'd0);
    chk("ill_enable", 32'(en2), 32'd0);
    chk("ill_ready", 32'(ready2), 32'd1);
    @(posedge clk); #1;
    chk("ill_error_end", 32'(err2), 32'd0);
    instr2 = 32'hFFFF_FF00;
    valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    chk("nop2_error", 32'(err2), 32'd0);
    chk("nop2_done", 32'(done2), 32'd0);
    chk("nop2_ready", 32'(ready2), 32'd1);
    instr2 = 32'd2;
    valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("nowd_enable", 32'(en2), 32'd2);
    chk("nowd_busy", 32'(busy2), 32'd1);
    rd2 = 2'b10;
    wr2 = 2'b10;
    @(posedge clk); #1;
    rd2 = '0;
    wr2 = '0;
    chk("nowd_done", 32'(done2), 32'd1);
    chk("nowd_error", 32'(err2), 32'd0);
    chk("nowd_enable_off", 32'(en2), 32'd0);
    @(posedge clk); #1;
    chk("nowd_ready", 32'(ready2), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_dispatch_ctrl.md
# acc_dispatch_ctrl

Registered dispatch controller for the communication-interface accelerators. It accepts one opcode at a time through a valid/ready handshake and enables exactly one of NUM_ACC accelerators. It waits until that accelerator reports both read and write completion, in either order, then reports completion. A watchdog aborts runs that never finish. It sits between the instruction decoder and the FFT/FIR/IIR accelerator bank and generalises the current fixed three-accelerator combinational logic array.

## Interface
- NUM_ACC, 3, number of accelerators (1..2^OPCODE_W-1)
- OPCODE_W, 2, opcode field width, taken from instruction[OPCODE_W-1:0]
- INSTR_W, 32, instruction bus width
- TIMEOUT_CYCLES, 1024, maximum cycles in RUN before abort; 0 disables the watchdog

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instruction  in  INSTR_W  instruction word; only the opcode field is decoded
- instr_valid  in  1  instruction is presented
- instr_ready  out  1  controller can accept an instruction
- read_done  in  NUM_ACC  per-accelerator read-complete level
- write_done  in  NUM_ACC  per-accelerator write-complete level
- acc_enable  out  NUM_ACC  one-hot enable, registered
- acc_done  out  1  one-cycle completion pulse
- acc_error  out  1  one-cycle pulse on illegal opcode or timeout
- busy  out  1  high in RUN and DONE

## Operation
- Reset values: acc_enable=0, acc_done=0, acc_error=0, busy=0, instr_ready=1, state IDLE, capture flags and watchdog cleared.
- Opcode decode:
  - 0 is NOP.
  - k in 1..NUM_ACC selects accelerator k-1. The default mapping is 1=FFT, 2=FIR, 3=IIR.
  - k>NUM_ACC is illegal.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready with a legal non-NOP opcode: latch sel, clear rd_seen/wr_seen, load the watchdog, go to RUN.
  - NOP: consumed, stay in IDLE, no pulse.
  - Illegal opcode: consumed, acc_error pulses, stay in IDLE.
- RUN:
  - acc_enable[sel]=1 and all other enables are 0.
  - rd_seen and wr_seen are sticky and are set from read_done[sel] and write_done[sel].
  - When both are set, or both inputs are high in the same cycle: acc_enable=0, go to DONE.
  - The watchdog decrements each cycle. If it reaches 0 (TIMEOUT_CYCLES>0) before completion: acc_enable=0, set the error flag, go to DONE.
- DONE:
  - acc_done pulses for one cycle; acc_error pulses with it if the run timed out.
  - Then go to IDLE.
- done inputs of non-selected accelerators are ignored in every state.
- Done inputs asserted in the same cycle the instruction is accepted are not captured; capture starts in the first RUN cycle.
- instruction and instr_valid are ignored outside IDLE (instr_ready=0).
- Reset asserted in any state clears all outputs immediately (asynchronously) and returns to IDLE; a pending run is dropped with no pulse.

## Timing
- Accept at edge N → acc_enable[sel]=1, busy=1, instr_ready=0 from N+1.
- Both flags first set, captured at edge M → acc_enable=0 and acc_done=1 during M+1 → instr_ready=1 from M+2.
- Minimum back-to-back period: 3 cycles when both done inputs are high in the first RUN cycle.
- Timeout: with TIMEOUT_CYCLES=T and no completion, acc_enable is high for exactly T cycles. acc_done and acc_error then pulse together for one cycle.
- Completion in the same cycle the watchdog expires counts as success; acc_error stays low.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package acc_dispatch_pkg:
  - state enum {IDLE, RUN, DONE}
  - OPC_NOP=0, OPC_FFT=1, OPC_FIR=2, OPC_IIR=3
  - the default NUM_ACC
- One sub-module, acc_watchdog: a loadable down-counter with an expired flag, parameterised by TIMEOUT_CYCLES. When TIMEOUT_CYCLES=0 it reduces to a constant expired=0.
- Opcode decode, capture flags and FSM live in the top.

## Test plan
- FFT run: opcode 1, read_done[0] high 4 cycles after enable, then write_done[0] 3 cycles later → acc_enable=3'b001 for exactly 8 cycles. One acc_done pulse follows, acc_error=0, instr_ready high two cycles after capture.
- Reverse order plus noise: opcode 3, write_done[2] before read_done[2], with read_done[0]/write_done[0] toggling → only the selected pair completes the run. acc_enable=3'b100 throughout.
- Illegal and NOP: NUM_ACC=2, opcode 3 → acc_error pulse, acc_enable stays 0. Opcode 0 → no pulses, instr_ready stays 1.
- Timeout: TIMEOUT_CYCLES=16, opcode 2, done inputs never asserted → acc_enable=3'b010 for 16 cycles. acc_done and acc_error then pulse in the same cycle.
- Reset mid-run: assert reset during RUN between clock edges → acc_enable=0 immediately with no acc_done. After release, a new opcode-1 run completes normally.
- Back-to-back: three valid instructions held continuously with done inputs tied high → each is accepted every 3 cycles in order 1, 2, 3.
